mul_unit: RTL and testbench
===========================

Name: mul_unit

Overview:
- Iterative shift-add multiplier sitting directly downstream of the multi-cycle controller.
- The controller flags MUL/UMULL/SMULL through opMul and IsLongMul; the datapath issues start with the register operands, and this block returns a 32- or 64-bit product plus N/Z flags.
- The FSM holds in its multiply state while busy=1 and writes back on done.
- One shift-add step per cycle: no combinational 32x32 array in the datapath.

Parameters:
- WIDTH, 32, operand width; products are 2*WIDTH wide.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 resets.
- start  input  1  request a multiply; honoured only in IDLE.
- IsLongMul  input  1  1 = UMULL/SMULL (64-bit result), 0 = MUL (low word only).
- IsSigned  input  1  1 = SMULL (Instr[22]); ignored when IsLongMul=0.
- SrcA  input  WIDTH  multiplicand (Rm).
- SrcB  input  WIDTH  multiplier (Rs).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; results valid.
- ResultLo  output  WIDTH  low product word.
- ResultHi  output  WIDTH  high product word; 0 for MUL.
- MulFlags  output  4  {N,Z,C,V}; C=V=0.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; busy=0; done=0; ResultLo=ResultHi=0; MulFlags=0; internal registers cleared.
  - Applies mid-operation: the operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - Entering: on an edge with start=1, capture mode and operands, count=0, accumulator=0, go RUN.
  - Operand capture for signed (IsLongMul=1 and IsSigned=1): capture |SrcA| and |SrcB|, and record neg = SrcA[WIDTH-1] ^ SrcB[WIDTH-1].
  - Operand capture otherwise: raw operands, neg=0.
  - |0x80000000| = 0x80000000, treated as unsigned.
- RUN:
  - Each edge: if multiplier bit0=1, add the multiplicand (zero-extended to 2*WIDTH) to the 2*WIDTH accumulator. Then shift the multiplicand left 1, shift the multiplier right 1, and increment count.
  - On the edge where count == WIDTH-1: perform the final step, then register the outputs and go DONE.
  - Output values registered on that edge:
    - P = neg ? two's-complement negate(accumulator) : accumulator.
    - ResultLo = P[WIDTH-1:0].
    - ResultHi = IsLongMul ? P[2W-1:W] : 0.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency:
  - Start sampled at edge E0; done=1 in the cycle following edge E0+WIDTH (WIDTH=32 → 32 edges).
  - busy=1 in the cycles following edges E0..E0+WIDTH-1.
- Results and MulFlags hold their values after done until the next DONE entry; they are not cleared by start.
- Flags:
  - N = IsLongMul ? ResultHi[WIDTH-1] : ResultLo[WIDTH-1].
  - Z = (IsLongMul ? {ResultHi,ResultLo} : ResultLo) == 0.
  - C=0, V=0.
  - Flags are registered together with the results.
- start while in RUN or DONE: ignored entirely. No queueing, and operands are not re-captured.
- start in the same cycle done=1: ignored. A new start is accepted only from IDLE, one cycle after done.
- Operand inputs are sampled only at the start edge; later changes have no effect.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, done=0, ResultLo=ResultHi=0, MulFlags=0000.
- MUL: start, IsLongMul=0, SrcA=7, SrcB=6 → busy for 32 cycles; done pulses once 32 edges after start; ResultLo=42, ResultHi=0, N=0, Z=0.
- UMULL: SrcA=SrcB=0xFFFFFFFF, IsSigned=0 → ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
- SMULL:
  - -1 × 2 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFE, N=1.
  - 0x80000000 × 0x80000000 → Hi=0x40000000, Lo=0, N=0.
- Busy/zero: MUL 0×5, pulse start again at cycle 10 with SrcA=3 → single done; ResultLo=0, Z=1. The second start produces no operation; busy=0 after the DONE cycle.
- Mid-op reset: start UMULL 5×5, assert reset=0 at cycle 10 → next cycle busy=0, results 0, no done. Then MUL 3×4 → ResultLo=12 after 32 cycles.

Source files
------------

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/UMULL/SMULL: one partial product per cycle,
// sign handled by magnitude multiply plus final conditional negate.
module mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             IsLongMul,
  input  logic             IsSigned,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       MulFlags
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic             long_q;
  logic             neg_q;

  logic             signed_mode;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             neg_in;
  logic [PW-1:0]    step_add;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] hi_nxt;
  logic             n_nxt;
  logic             z_nxt;
  logic             last_step;
  logic             capture;
  logic             load_res;
  logic             busy_nxt;
  logic             done_nxt;

  // Operand conditioning: SMULL multiplies magnitudes; the most negative value maps to itself.
  always_comb begin
    signed_mode = IsLongMul & IsSigned;
    abs_a       = (signed_mode && SrcA[WIDTH-1]) ? (WIDTH'(0) - SrcA) : SrcA;
    abs_b       = (signed_mode && SrcB[WIDTH-1]) ? (WIDTH'(0) - SrcB) : SrcB;
    neg_in      = signed_mode & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
  end

  // Step arithmetic and the final product/flag values loaded on the last step.
  always_comb begin
    step_add  = mplier[0] ? mcand : '0;
    acc_step  = acc + step_add;
    prod      = neg_q ? (PW'(0) - acc_step) : acc_step;
    lo_nxt    = prod[WIDTH-1:0];
    hi_nxt    = long_q ? prod[PW-1:WIDTH] : '0;
    n_nxt     = long_q ? prod[PW-1] : prod[WIDTH-1];
    z_nxt     = (lo_nxt == '0) && (hi_nxt == '0);
    last_step = (count == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode, registered below.
  always_comb begin
    capture  = 1'b0;
    load_res = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE:    capture  = start;
      RUN:     load_res = last_step;
      default: ;
    endcase
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  // Multiplier datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      long_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (capture) begin
      mcand  <= PW'(abs_a);
      mplier <= abs_b;
      acc    <= '0;
      count  <= '0;
      long_q <= IsLongMul;
      neg_q  <= neg_in;
    end else if (state == RUN) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

  // Registered outputs; results and flags persist until the next completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulFlags <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (load_res) begin
        ResultLo <= lo_nxt;
        ResultHi <= hi_nxt;
        MulFlags <= {n_nxt, z_nxt, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed and randomized checks of mul_unit against a plain-arithmetic product model.
module tb_mul_unit;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          IsLongMul;
  logic          IsSigned;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic          busy;
  logic          done;
  logic [W-1:0]  ResultLo;
  logic [W-1:0]  ResultHi;
  logic [3:0]    MulFlags;

  int            ncmp;
  int            nfail;
  logic [W-1:0]  exp_lo;
  logic [W-1:0]  exp_hi;
  logic [3:0]    exp_fl;

  mul_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .IsLongMul (IsLongMul),
    .IsSigned  (IsSigned),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .busy      (busy),
    .done      (done),
    .ResultLo  (ResultLo),
    .ResultHi  (ResultHi),
    .MulFlags  (MulFlags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural product: full 64-bit value, low word only for MUL.
  function automatic logic [63:0] ref_prod(input bit lng, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    if (lng && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = 64'(a) * 64'(b);
    end
    if (!lng) p = {32'h0, p[31:0]};
    return p;
  endfunction

  function automatic logic [3:0] ref_flags(input bit lng, input logic [63:0] p);
    logic n;
    logic z;
    n = lng ? p[63] : p[31];
    z = (p == 64'h0);
    return {n, z, 2'b00};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One full operation with exact-latency checks; optional stray starts mid-run / on done.
  task automatic run_op(input bit lng, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input bit pulse_done);
    logic [63:0] p;
    logic [3:0]  f;
    int          nbusy;
    int          ndone;
    p = ref_prod(lng, sgn, a, b);
    f = ref_flags(lng, p);
    @(negedge clk);
    IsLongMul = lng;
    IsSigned  = sgn;
    SrcA      = a;
    SrcB      = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    SrcA      = $urandom;
    SrcB      = $urandom;
    IsLongMul = 1'($urandom);
    IsSigned  = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));
    check("hold_lo", 64'(ResultLo), 64'(exp_lo));
    check("hold_hi", 64'(ResultHi), 64'(exp_hi));
    check("hold_flags", 64'(MulFlags), 64'(exp_fl));
    nbusy = 0;
    ndone = 0;
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      nbusy += int'(busy);
      ndone += int'(done);
      if (i == pulse_at) begin
        start = 1'b1;
        SrcA  = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_cycles", 64'(nbusy), 64'(W - 1));
    check("early_done", 64'(ndone), 64'(0));
    @(posedge clk);
    #1;
    exp_lo = p[31:0];
    exp_hi = p[63:32];
    exp_fl = f;
    check("done_pulse", 64'(done), 64'(1));
    check("busy_at_done", 64'(busy), 64'(0));
    check("result_lo", 64'(ResultLo), 64'(exp_lo));
    check("result_hi", 64'(ResultHi), 64'(exp_hi));
    check("flags", 64'(MulFlags), 64'(exp_fl));
    start = pulse_done;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
  endtask

  initial begin
    int ndone;
    int nbusy;
    clk       = 1'b0;
    reset     = 1'b0;
    start     = 1'b1;
    IsLongMul = 1'b0;
    IsSigned  = 1'b0;
    SrcA      = 32'd7;
    SrcB      = 32'd6;
    ncmp      = 0;
    nfail     = 0;
    exp_lo    = '0;
    exp_hi    = '0;
    exp_fl    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_lo", 64'(ResultLo), 64'(0));
    check("rst_hi", 64'(ResultHi), 64'(0));
    check("rst_flags", 64'(MulFlags), 64'(0));
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;

    run_op(1'b0, 1'b0, 32'd7, 32'd6, 0, 1'b0);
    check("mul_7x6", 64'(exp_lo), 64'(42));
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    run_op(1'b0, 1'b0, 32'd0, 32'd5, 10, 1'b1);

    // Reset in the middle of a run discards it and clears results.
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
    @(negedge clk);
    IsLongMul = 1'b1;
    IsSigned  = 1'b0;
    SrcA      = 32'd5;
    SrcB      = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_lo", 64'(ResultLo), 64'(0));
    check("midrst_hi", 64'(ResultHi), 64'(0));
    check("midrst_flags", 64'(MulFlags), 64'(0));
    exp_lo = '0;
    exp_hi = '0;
    exp_fl = '0;
    reset  = 1'b1;
    ndone  = 0;
    nbusy  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      ndone += int'(done);
      nbusy += int'(busy);
    end
    check("midrst_no_done", 64'(ndone), 64'(0));
    check("midrst_no_busy", 64'(nbusy), 64'(0));
    run_op(1'b0, 1'b0, 32'd3, 32'd4, 0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      run_op(mode != 0, mode == 2, pick_operand(), pick_operand(), 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
